xsw_egress_reader: RTL

XSW_EGRESS_READER -- requirements
Module: xsw_egress_reader

---
 rtl/xsw_pkg.sv | 23 ++
 rtl/xsw_rr_arbiter.sv | 43 ++++
 rtl/xsw_egress_reader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/xsw_pkg.sv
// ----------------------------------------------------------------------------
// xsw_pkg
// Shared definitions for the switch egress reader slice.
//   NPORTS        : default number of switch egress ports
//   LANE_W        : default width of one address/data lane
//   CFG_MASK_ADDR : config-bus address of the port enable mask register
//   xsw_state_e   : reader FSM states
// ----------------------------------------------------------------------------
package xsw_pkg;

   localparam int NPORTS = 8;
   localparam int LANE_W = 8;

   localparam logic [15:0] CFG_MASK_ADDR = 16'h0000;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      READ = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } xsw_state_e;

endpackage : xsw_pkg

// File: rtl/xsw_rr_arbiter.sv
// ----------------------------------------------------------------------------
// xsw_rr_arbiter
// Combinational round-robin pick: returns the first requesting port at or
// after ptr_i, wrapping from NPORTS-1 back to 0.
//   req_i   : per-port request vector
//   ptr_i   : index where the search starts (must be < NPORTS)
//   grant_o : one-hot grant (zero when nothing requests)
//   idx_o   : binary index of the granted port
//   valid_o : at least one port requests
// ----------------------------------------------------------------------------
module xsw_rr_arbiter #(
   parameter int NPORTS = 8,
   parameter int IDX_W  = 3
) (
   input  logic [NPORTS-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NPORTS-1:0] grant_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              valid_o
);

   // Walk the ports in priority order starting from the pointer; the first
   // hit wins and later candidates are ignored once valid_o is set.
   always_comb begin
      int cand;
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int k = 0; k < NPORTS; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= NPORTS) begin
            cand = cand - NPORTS;
         end
         if (!valid_o && req_i[cand]) begin
            valid_o       = 1'b1;
            idx_o         = IDX_W'(cand);
            grant_o[cand] = 1'b1;
         end
      end
   end

endmodule : xsw_rr_arbiter

// File: rtl/xsw_egress_reader.sv
// ----------------------------------------------------------------------------
// xsw_egress_reader
// Pulls one word at a time out of the switch egress FIFOs in round-robin
// order and presents each as a packet on a valid/ready stream.
//   clk, reset          : clock, asynchronous active-high reset
//   data_rdy, fifo_empty: per-port status from the switch
//   addr_out, data_out  : per-port lanes (lane i = [i*LANE_W +: LANE_W])
//   rd_en               : one-hot FIFO pop strobe back to the switch
//   port_en/wr/addr/sel : config write bus (mask register at CFG_MASK_ADDR)
//   pkt_valid/ready/port/addr/data : collected packet stream
//   rd_count            : saturating count of pops issued
// RD_LAT (1..3) is the number of cycles between the pop strobe and the lane
// holding the popped word.
// ----------------------------------------------------------------------------
module xsw_egress_reader #(
   parameter int NPORTS = xsw_pkg::NPORTS,
   parameter int LANE_W = xsw_pkg::LANE_W,
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NPORTS-1:0]        data_rdy,
   input  logic [NPORTS-1:0]        fifo_empty,
   input  logic [NPORTS*LANE_W-1:0] addr_out,
   input  logic [NPORTS*LANE_W-1:0] data_out,
   output logic [NPORTS-1:0]        rd_en,
   input  logic                     port_en,
   input  logic                     port_wr,
   input  logic [15:0]              port_addr,
   input  logic [NPORTS-1:0]        port_sel,
   output logic                     pkt_valid,
   input  logic                     pkt_ready,
   output logic [2:0]               pkt_port,
   output logic [LANE_W-1:0]        pkt_addr,
   output logic [LANE_W-1:0]        pkt_data,
   output logic [15:0]              rd_count
);

   import xsw_pkg::*;

   localparam int IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int WAIT_W = 2;

   xsw_state_e            state_q, state_d;
   logic [IDX_W-1:0]      rrPtr_q;
   logic [NPORTS-1:0]     mask_q;
   logic [IDX_W-1:0]      grantIdx_q;
   logic [NPORTS-1:0]     grantOh_q;
   logic [WAIT_W-1:0]     waitCnt_q;
   logic                  pktValid_q;
   logic [2:0]            pktPort_q;
   logic [LANE_W-1:0]     pktAddr_q;
   logic [LANE_W-1:0]     pktData_q;
   logic [15:0]           rdCount_q;

   logic [NPORTS-1:0]     eligible;
   logic [NPORTS-1:0]     arbGrant;
   logic [IDX_W-1:0]      arbIdx;
   logic                  arbValid;
   logic                  cfgMaskWrite;
   logic                  waitDone;
   logic                  pktAccept;
   logic [IDX_W-1:0]      nextPtr;

   // Eligibility uses the registered mask, so a mask write landing in the
   // same cycle as arbitration only takes effect from the next ARB onward.
   assign eligible     = mask_q & data_rdy & ~fifo_empty;
   assign cfgMaskWrite = port_en && port_wr && (port_addr == CFG_MASK_ADDR);
   assign waitDone     = (waitCnt_q == WAIT_W'(RD_LAT - 1));
   assign pktAccept    = pktValid_q && pkt_ready;
   assign nextPtr      = (grantIdx_q == IDX_W'(NPORTS - 1)) ? '0 : grantIdx_q + 1'b1;

   xsw_rr_arbiter #(
      .NPORTS (NPORTS),
      .IDX_W  (IDX_W)
   ) u_arb (
      .req_i   (eligible),
      .ptr_i   (rrPtr_q),
      .grant_o (arbGrant),
      .idx_o   (arbIdx),
      .valid_o (arbValid)
   );

   // State and datapath registers. The grant is frozen in ARB, so later mask
   // changes or a port dropping its ready cannot disturb an issued read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ARB;
         rrPtr_q    <= '0;
         mask_q     <= '1;
         grantIdx_q <= '0;
         grantOh_q  <= '0;
         waitCnt_q  <= '0;
         pktValid_q <= 1'b0;
         pktPort_q  <= '0;
         pktAddr_q  <= '0;
         pktData_q  <= '0;
         rdCount_q  <= '0;
      end else begin
         state_q <= state_d;
         if (cfgMaskWrite) begin
            mask_q <= port_sel;
         end
         case (state_q)
            ARB: begin
               if (arbValid) begin
                  grantIdx_q <= arbIdx;
                  grantOh_q  <= arbGrant;
               end
            end
            READ: begin
               waitCnt_q <= '0;
               if (rdCount_q != 16'hFFFF) begin
                  rdCount_q <= rdCount_q + 16'd1;
               end
            end
            WAIT: begin
               if (waitDone) begin
                  pktValid_q <= 1'b1;
                  pktPort_q  <= 3'(grantIdx_q);
                  pktAddr_q  <= addr_out[grantIdx_q*LANE_W +: LANE_W];
                  pktData_q  <= data_out[grantIdx_q*LANE_W +: LANE_W];
               end else begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (pktAccept) begin
                  pktValid_q <= 1'b0;
                  rrPtr_q    <= nextPtr;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state logic: one pass ARB -> READ -> WAIT (RD_LAT cycles) -> HOLD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (arbValid)  state_d = READ;
         READ:                   state_d = WAIT;
         WAIT:    if (waitDone)  state_d = HOLD;
         HOLD:    if (pktAccept) state_d = ARB;
         default:                state_d = ARB;
      endcase
   end

   // The pop strobe is decoded from the state so it can only be live during
   // READ, and it is exactly the one-hot grant captured in ARB.
   always_comb begin
      rd_en = '0;
      if (state_q == READ) begin
         rd_en = grantOh_q;
      end
   end

   assign pkt_valid = pktValid_q;
   assign pkt_port  = pktPort_q;
   assign pkt_addr  = pktAddr_q;
   assign pkt_data  = pktData_q;
   assign rd_count  = rdCount_q;

endmodule : xsw_egress_reader
